// File: rtl/data_capture_fifo.sv
// ---------------------------------------------------------------------------
// data_capture_fifo
//   Show-ahead synchronous FIFO that captures words from a launch register
//   stage. Words arriving while the FIFO is full (and no read frees a slot in
//   the same cycle) are dropped and flagged by a sticky overflow bit.
//
// Optional feature macro: DATA_CAPTURE_DROP_COUNT_EN
//   defined   -> drop_cnt counts dropped words (saturating at 255, cleared by
//                reset or clr_ovf; a drop coinciding with clr_ovf gives 1).
//   undefined -> drop_cnt is tied to 0 and no counter is built.
//
// Parameters
//   WIDTH  data word width
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      asynchronous active-low reset
//   in_valid   upstream word present this cycle
//   in_data    upstream word
//   out_valid  head entry available (== !empty)
//   out_ready  downstream accepts the head entry this cycle
//   out_data   head entry (show-ahead), don't-care when empty
//   full       count == DEPTH
//   empty      count == 0
//   count      number of occupied entries
//   clr_ovf    synchronous clear of overflow (and drop_cnt)
//   overflow   sticky: a word was dropped
//   drop_cnt   number of dropped words (feature-dependent, see above)
//
// Handshake: a read transfers when out_valid && out_ready are both 1 at a
// rising clock edge. The input side has no back-pressure: a word with
// in_valid=1 is written when the FIFO is not full or when a read fires in
// the same cycle; otherwise it is dropped.
// ---------------------------------------------------------------------------
module data_capture_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_ovf,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_rd_fire;
  logic w_wr_fire;
  logic w_drop;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_rd_fire = ~w_empty & out_ready;
  // A read in the same cycle frees the slot the write needs when full.
  assign w_wr_fire = in_valid & (~w_full | w_rd_fire);
  assign w_drop    = in_valid & w_full & ~w_rd_fire;

  // Storage is not reset; out_data is don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Pointer wrap is implicit: DEPTH is a power of two.
      if (w_wr_fire) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_fire, w_rd_fire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Set wins over clear when a drop coincides with clr_ovf.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef DATA_CAPTURE_DROP_COUNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      if (clr_ovf) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (clr_ovf) begin
      r_drop_cnt <= 8'd0;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 8'd0;
`endif

  assign out_valid = ~w_empty;
  assign out_data  = r_mem[r_rd_ptr];
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_data_capture_fifo.sv
// ---------------------------------------------------------------------------
// tb_data_capture_fifo
//   Directed bench for data_capture_fifo (WIDTH=4, DEPTH=4). Words that are
//   expected to be accepted are pushed into exp_q by the driver; a monitor
//   pops and compares whenever a read transfer is presented.
// ---------------------------------------------------------------------------
module tb_data_capture_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             full;
  logic             empty;
  logic [2:0]       count;
  logic             clr_ovf = 1'b0;
  logic             overflow;
  logic [7:0]       drop_cnt;

  logic [WIDTH-1:0] exp_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;

`ifdef DATA_CAPTURE_DROP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  data_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .clr_ovf   (clr_ovf),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input int exp_count, input bit exp_ovf,
                             input int exp_drop);
    check({tag, ".count"},    32'(count),     32'(exp_count));
    check({tag, ".empty"},    32'(empty),     32'(exp_count == 0));
    check({tag, ".full"},     32'(full),      32'(exp_count == DEPTH));
    check({tag, ".out_valid"},32'(out_valid), 32'(exp_count != 0));
    check({tag, ".overflow"}, 32'(overflow),  32'(exp_ovf));
    check({tag, ".drop_cnt"}, 32'(drop_cnt),  CNT_EN ? 32'(exp_drop) : 32'd0);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; applies inputs, waits through one edge, returns at
  // posedge+1 with the edge's effect visible.
  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit acc);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected none at %0t", out_data, $time);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %0h expected %0h at %0t", out_data, e, $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset asserted mid-cycle: outputs must clear immediately.
    #2 reset = 1'b0;
    #1;
    check_state("reset", 0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Two writes, then drain with show-ahead output.
    step(1'b1, 4'hA, 1'b0, 1'b1);
    check("lat.out_data", 32'(out_data), 32'hA);
    check_state("lat", 1, 1'b0, 0);
    step(1'b1, 4'h5, 1'b0, 1'b1);
    check_state("two", 2, 1'b0, 0);
    check("two.out_data", 32'(out_data), 32'hA);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check("pop1.out_data", 32'(out_data), 32'h5);
    check_state("pop1", 1, 1'b0, 0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check_state("drained", 0, 1'b0, 0);

    // Empty with in_valid and out_ready: write accepted, no read.
    step(1'b1, 4'hC, 1'b1, 1'b1);
    check_state("empty_wr_rd", 1, 1'b0, 0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check_state("empty_wr_rd_drain", 0, 1'b0, 0);

    // Fill, then drop one word.
    for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b1);
    check_state("fill", 4, 1'b0, 0);
    step(1'b1, 4'hF, 1'b0, 1'b0);
    check_state("drop1", 4, 1'b1, 1);
    check("drop1.out_data", 32'(out_data), 32'h1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check_state("ovf_sticky", 4, 1'b1, 1);
    clr_ovf = 1'b1;
    step(1'b0, 4'h0, 1'b0, 1'b0);
    clr_ovf = 1'b0;
    check_state("clr1", 4, 1'b0, 0);

    // Full with write and read together: 1 out, 9 in, count stays 4.
    step(1'b1, 4'h9, 1'b1, 1'b1);
    check_state("full_wr_rd", 4, 1'b0, 0);
    check("full_wr_rd.out_data", 32'(out_data), 32'h2);

    // 300 drops: counter saturates, storage untouched.
    for (int i = 0; i < 300; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    check_state("sat", 4, 1'b1, 255);
    check("sat.out_data", 32'(out_data), 32'h2);
    // Drop and clear coincide: overflow stays set, counter restarts at 1.
    clr_ovf = 1'b1;
    step(1'b1, 4'hE, 1'b0, 1'b0);
    check_state("clr_drop", 4, 1'b1, 1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    clr_ovf = 1'b0;
    check_state("clr2", 4, 1'b0, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    check_state("drain2", 0, 1'b0, 0);

    // Stream 0..9 with out_ready held: one word in flight, pointers wrap.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, WIDTH'(i), 1'b1, 1'b1);
      check("stream.count", 32'(count), 32'd1);
      check("stream.out_data", 32'(out_data), 32'(i));
    end
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check_state("stream_end", 0, 1'b0, 0);

    // Reset pulse between edges discards stored words.
    step(1'b1, 4'h7, 1'b0, 1'b1);
    step(1'b1, 4'h8, 1'b0, 1'b1);
    step(1'b1, 4'h6, 1'b0, 1'b1);
    in_valid = 1'b0;
    check_state("pre_rst", 3, 1'b0, 0);
    #2 reset = 1'b0;
    #1;
    check_state("mid_rst", 0, 1'b0, 0);
    exp_q.delete();
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 4'h3, 1'b0, 1'b1);
    check("post_rst.out_data", 32'(out_data), 32'h3);
    check_state("post_rst", 1, 1'b0, 0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    out_ready = 1'b0;
    check_state("final", 0, 1'b0, 0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_capture_fifo.md
DATA_CAPTURE_FIFO -- requirements
Module: data_capture_fifo

Interface
REQ-001 Parameter WIDTH, default 4, data word width; matches the launch register output width.
REQ-002 Parameter DEPTH, default 4, number of storage entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 in_valid  input  1  upstream word present this cycle; driven from the launch-stage enable delayed one cycle.
REQ-006 in_data  input  WIDTH  captured word, driven by the launch-stage q output.
REQ-007 out_valid  output  1  head entry available.
REQ-008 out_ready  input  1  downstream accepts the head entry this cycle.
REQ-009 out_data  output  WIDTH  head entry (show-ahead).
REQ-010 full  output  1  count equals DEPTH.
REQ-011 empty  output  1  count equals 0.
REQ-012 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-013 clr_ovf  input  1  synchronous clear of the overflow status.
REQ-014 overflow  output  1  sticky: a word was dropped.
REQ-015 drop_cnt  output  8  count of dropped words (see Configuration).

Function
REQ-016 Read fires when out_valid and out_ready are both 1; head advances at the next edge.
REQ-017 Write fires when in_valid is 1 and either full is 0 or a read fires in the same cycle.
REQ-018 A write SHALL store in_data at the tail, and the tail pointer SHALL advance modulo DEPTH.
REQ-019 The head pointer SHALL advance modulo DEPTH on a read; both pointers wrap from DEPTH-1 to 0.
REQ-020 count update: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-021 out_valid SHALL equal not empty; out_data SHALL be the head entry, and its value is don't-care when empty.
REQ-022 Latency: a word written at edge N SHALL appear on out_data with out_valid=1 after edge N when the FIFO was empty; there is no combinational in-to-out path.
REQ-023 Empty with in_valid=1 and out_ready=1: no read fires; the write is accepted.
REQ-024 Full with in_valid=1 and out_ready=1: read and write both fire; count stays DEPTH.
REQ-025 Full with in_valid=1 and out_ready=0: the word is dropped, storage is unchanged, and overflow is set at the next edge.
REQ-026 Once set, overflow SHALL hold until clr_ovf=1 at an edge or reset.
REQ-027 If clr_ovf=1 and a drop occur in the same cycle, overflow SHALL remain 1 (set wins).
REQ-028 full and empty SHALL be derived from count and never both 1.

Reset
REQ-029 While reset=0: pointers=0, count=0, empty=1, full=0, out_valid=0, overflow=0, drop_cnt=0, all effective immediately.
REQ-030 Storage contents need not be cleared; out_data is don't-care while empty.
REQ-031 Reset asserted mid-operation SHALL discard all stored words; the first edge after release SHALL behave as from empty.

Configuration
REQ-032 Macro DATA_CAPTURE_DROP_COUNT_EN defined: drop_cnt SHALL increment by 1 on every dropped word, saturate at 255, and clear on reset or clr_ovf.
REQ-033 If clr_ovf and a drop coincide, drop_cnt SHALL become 1.
REQ-034 Macro undefined: drop_cnt SHALL be constant 0 and no counter logic is instantiated; overflow behaviour is unchanged.

Verification
REQ-035 Reset then write 4'hA, 4'h5 with out_ready=0 -> count=2, out_data=4'hA; then out_ready=1 for two cycles -> out_data 4'hA then 4'h5, then empty=1.
REQ-036 Fill with 1,2,3,4 (DEPTH=4) -> full=1; in_valid with 4'hF and out_ready=0 -> 4'hF dropped, overflow=1, drop_cnt=1 (macro on) or 0 (macro off).
REQ-037 Full with in_valid=1 (4'h9) and out_ready=1 -> output 1 popped, 4'h9 stored, count stays 4, overflow stays 0.
REQ-038 Stream 10 words 0..9 with out_ready=1 continuously -> outputs 0..9 in order, one cycle late, no drops, pointer wrap exercised.
REQ-039 Hold full and drive 300 drops -> drop_cnt saturates at 255; clr_ovf=1 -> overflow=0 and drop_cnt=0 at the next edge.
REQ-040 Three words stored, reset pulsed low between edges -> count=0 and empty=1 immediately; after release, write 4'h3 -> out_data=4'h3, count=1.
